axis_pps_generator: RTL

//  Generates a 1 PPS-style pulse train on aclk from period values received on an AXI-Stream slave.

---
 rtl/axis_pps_generator_pkg.sv | 9 +
 rtl/axis_pps_generator.sv | 110 +++++++++++
 2 files changed

// File: rtl/axis_pps_generator_pkg.sv
// Shared types for the AXI-Stream PPS pulse generator.
package axis_pps_generator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/axis_pps_generator.sv
// PPS pulse generator: period from AXI-Stream, width from cfg_data, both latched at second boundaries.
// Optional seconds counter on sts_data when AXIS_PPS_GENERATOR_SECONDS_EN is defined.
module axis_pps_generator
    import axis_pps_generator_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        en,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic                        pps_out
`ifdef AXIS_PPS_GENERATOR_SECONDS_EN
    ,
    output logic [CNTR_WIDTH-1:0]       sts_data
`endif
);

    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] TWO = CNTR_WIDTH'(2);

    state_t                  state, state_n;
    logic [CNTR_WIDTH-1:0]   cntr, cntr_n;
    logic [CNTR_WIDTH-1:0]   period, period_n;
    logic [CNTR_WIDTH-1:0]   width, width_n;
    logic [CNTR_WIDTH-1:0]   weff_n;
    logic [CNTR_WIDTH-1:0]   p_in;
    logic                    p_ok;
    logic                    boundary;
    logic                    pps_n;

    assign p_in     = s_axis_tdata[CNTR_WIDTH-1:0];
    assign p_ok     = (p_in >= TWO);
    assign boundary = (cntr == period - ONE);

    always_comb begin
        state_n       = state;
        cntr_n        = cntr;
        period_n      = period;
        width_n       = width;
        s_axis_tready = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = en;
                cntr_n        = '0;
                if (en && s_axis_tvalid && p_ok) begin
                    period_n = p_in;
                    width_n  = cfg_data;
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                    cntr_n  = '0;
                end else if (boundary) begin
                    s_axis_tready = 1'b1;
                    cntr_n        = '0;
                    width_n       = cfg_data;
                    if (s_axis_tvalid && p_ok) begin
                        period_n = p_in;
                    end
                end else begin
                    cntr_n = cntr + ONE;
                end
            end
            default: state_n = IDLE;
        endcase
        // Clamp to period-1 so the output always drops for at least one cycle per second.
        weff_n = (width_n < period_n - ONE) ? width_n : (period_n - ONE);
        pps_n  = (state_n == RUN) && (cntr_n < weff_n);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            cntr    <= '0;
            period  <= '0;
            width   <= '0;
            pps_out <= 1'b0;
        end else begin
            state   <= state_n;
            cntr    <= cntr_n;
            period  <= period_n;
            width   <= width_n;
            pps_out <= pps_n;
        end
    end

`ifdef AXIS_PPS_GENERATOR_SECONDS_EN
    logic [CNTR_WIDTH-1:0] weff;
    logic                  rise;

    assign weff = (width < period - ONE) ? width : (period - ONE);
    assign rise = (state == RUN) && (cntr == '0) && (weff != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_data <= '0;
        end else if (rise) begin
            sts_data <= sts_data + ONE;
        end
    end
`endif

endmodule
